// File: rtl/vp_mbox.sv
// vp_mbox: dual-port Qbus mailbox with CHANNELS byte channels and one FIFO per direction.
// Each bus side decodes DL11-style CSR/buffer registers and raises a vectored interrupt.

module vp_mbox_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty,
  output logic       full,
  output logic       drop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

module vp_mbox_side #(
  parameter int          CHANNELS = 3,
  parameter logic [15:0] BASE     = 16'o176640,
  parameter logic [15:0] VEC      = 16'o000440
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           ad_in,
  output logic [15:0]           ad_out,
  output logic                  ad_oe,
  input  logic                  sync_n,
  input  logic                  din_n,
  input  logic                  dout_n,
  input  logic                  iaki_n,
  output logic                  rply_n,
  output logic                  virq_n,
  output logic                  iako_n,
  output logic [CHANNELS-1:0]   push,
  output logic [7:0]            push_data,
  output logic [CHANNELS-1:0]   pop,
  input  logic [CHANNELS-1:0]   rx_empty,
  input  logic [CHANNELS*8-1:0] rx_head,
  input  logic [CHANNELS-1:0]   tx_full,
  input  logic [CHANNELS-1:0]   tx_drop
);
  typedef enum logic [2:0] {
    S_IDLE, S_RD_DATA, S_RD_RPLY, S_WR_RPLY, S_IAK_DATA, S_IAK_RPLY, S_PASS
  } state_t;

  localparam logic [15:0] SPAN = 16'(8 * CHANNELS);

  state_t              state, state_nx;
  logic                sync_prev, sync_q, din_q, dout_q, iak_q, iak_qq;
  logic                sel;
  logic [1:0]          sel_ch, sel_reg;
  logic [15:0]         addr, off, wdata, read_val, vector;
  logic [15:0]         data_r, data_nx;
  logic                pop_pending, pop_pending_nx, wr_en, hit, any_req;
  logic [CHANNELS-1:0] rie, xie, xovr, rx_req, tx_req;

  assign addr      = ~ad_in;
  assign wdata     = ~ad_in;
  assign push_data = wdata[7:0];
  assign off       = addr - BASE;
  assign hit       = !addr[0] && (addr >= BASE) && (off < SPAN);

  // Strobes are registered once; the FSM acts on the registered copies.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_prev <= 1'b0;
      sync_q    <= 1'b0;
      din_q     <= 1'b0;
      dout_q    <= 1'b0;
      iak_q     <= 1'b0;
      iak_qq    <= 1'b0;
      sel       <= 1'b0;
      sel_ch    <= '0;
      sel_reg   <= '0;
    end else begin
      sync_prev <= sync_n;
      sync_q    <= !sync_n;
      din_q     <= !din_n;
      dout_q    <= !dout_n;
      iak_q     <= !iaki_n;
      iak_qq    <= iak_q;
      if (sync_n) begin
        sel <= 1'b0;
      end else if (sync_prev) begin
        sel <= hit;
        if (hit) begin
          sel_ch  <= off[4:3];
          sel_reg <= off[2:1];
        end
      end
    end
  end

  // Descending scan so the lowest channel, and rx within it, wins.
  always_comb begin
    rx_req  = rie & ~rx_empty;
    tx_req  = xie & ~tx_full;
    any_req = |{rx_req, tx_req};
    vector  = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (tx_req[k]) vector = VEC + 16'(8 * k + 4);
      if (rx_req[k]) vector = VEC + 16'(8 * k);
    end
  end

  always_comb begin
    read_val = '0;
    case (sel_reg)
      2'd0:    read_val = {8'd0, !rx_empty[sel_ch], rie[sel_ch], 6'd0};
      2'd1:    read_val = {8'd0, rx_empty[sel_ch] ? 8'd0 : rx_head[{sel_ch, 3'b000} +: 8]};
      2'd2:    read_val = {xovr[sel_ch], 7'd0, !tx_full[sel_ch], xie[sel_ch], 6'd0};
      default: read_val = '0;
    endcase
  end

  always_comb begin
    state_nx       = state;
    data_nx        = data_r;
    pop_pending_nx = pop_pending;
    wr_en          = 1'b0;
    pop            = '0;
    case (state)
      S_IDLE: begin
        if (iak_q && !iak_qq && din_q && sync_q) begin
          if (any_req) begin
            state_nx = S_IAK_DATA;
            data_nx  = vector;
          end else begin
            state_nx = S_PASS;
          end
        end else if (sel && din_q) begin
          state_nx       = S_RD_DATA;
          data_nx        = read_val;
          pop_pending_nx = (sel_reg == 2'd1) && !rx_empty[sel_ch];
        end else if (sel && dout_q) begin
          state_nx = S_WR_RPLY;
          wr_en    = 1'b1;
        end
      end
      // Pop only the byte actually latched for this read, on the reply edge.
      S_RD_DATA: begin
        state_nx       = S_RD_RPLY;
        pop_pending_nx = 1'b0;
        if (pop_pending) pop[sel_ch] = 1'b1;
      end
      S_IAK_DATA: state_nx = S_IAK_RPLY;
      S_RD_RPLY, S_IAK_RPLY: begin
        if (!din_q) begin
          state_nx = S_IDLE;
          data_nx  = '0;
        end
      end
      S_WR_RPLY: if (!dout_q) state_nx = S_IDLE;
      S_PASS:    if (!iak_q) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    push = '0;
    if (wr_en && sel_reg == 2'd3) push[sel_ch] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      data_r      <= '0;
      pop_pending <= 1'b0;
      rie         <= '0;
      xie         <= '0;
      xovr        <= '0;
    end else begin
      state       <= state_nx;
      data_r      <= data_nx;
      pop_pending <= pop_pending_nx;
      xovr        <= xovr | tx_drop;
      if (wr_en) begin
        case (sel_reg)
          2'd0: rie[sel_ch] <= wdata[6];
          2'd2: begin
            xie[sel_ch]  <= wdata[6];
            xovr[sel_ch] <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign ad_oe  = (state == S_RD_DATA) || (state == S_RD_RPLY) ||
                  (state == S_IAK_DATA) || (state == S_IAK_RPLY);
  assign ad_out = ad_oe ? ~data_r : 16'hFFFF;
  assign rply_n = !((state == S_RD_RPLY) || (state == S_WR_RPLY) || (state == S_IAK_RPLY));
  assign virq_n = !any_req;
  assign iako_n = (state == S_PASS) ? iaki_n : 1'b1;
endmodule

module vp_mbox #(
  parameter int          CHANNELS = 3,
  parameter int          DEPTH    = 4,
  parameter logic [15:0] C_BASE   = 16'o176640,
  parameter logic [15:0] P_BASE   = 16'o177040,
  parameter logic [15:0] C_VEC    = 16'o000440,
  parameter logic [15:0] P_VEC    = 16'o000300
) (
  input  logic        PIN_CLK,
  input  logic        PIN_nINIT,
  input  logic [15:0] PIN_nADC_in,
  output logic [15:0] PIN_nADC_out,
  output logic        PIN_nADC_oe,
  input  logic        PIN_nSYNCC,
  input  logic        PIN_nDINC,
  input  logic        PIN_nDOUTC,
  input  logic        PIN_nIAKIC,
  output logic        PIN_nRPLYC,
  output logic        PIN_nVIRQC,
  output logic        PIN_nIAKOC,
  input  logic [15:0] PIN_nADP_in,
  output logic [15:0] PIN_nADP_out,
  output logic        PIN_nADP_oe,
  input  logic        PIN_nSYNCP,
  input  logic        PIN_nDINP,
  input  logic        PIN_nDOUTP,
  input  logic        PIN_nIAKIP,
  output logic        PIN_nRPLYP,
  output logic        PIN_nVIRQP,
  output logic        PIN_nIAKOP
);
  logic [CHANNELS-1:0]   c_push, c_pop, p_push, p_pop;
  logic [7:0]            c_push_data, p_push_data;
  logic [CHANNELS*8-1:0] c2p_head, p2c_head;
  logic [CHANNELS-1:0]   c2p_empty, c2p_full, c2p_drop, p2c_empty, p2c_full, p2c_drop;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    vp_mbox_fifo #(.DEPTH(DEPTH)) u_c2p (
      .clk(PIN_CLK), .rst_n(PIN_nINIT), .push(c_push[k]), .push_data(c_push_data),
      .pop(p_pop[k]), .head(c2p_head[k*8 +: 8]), .empty(c2p_empty[k]),
      .full(c2p_full[k]), .drop(c2p_drop[k])
    );
    vp_mbox_fifo #(.DEPTH(DEPTH)) u_p2c (
      .clk(PIN_CLK), .rst_n(PIN_nINIT), .push(p_push[k]), .push_data(p_push_data),
      .pop(c_pop[k]), .head(p2c_head[k*8 +: 8]), .empty(p2c_empty[k]),
      .full(p2c_full[k]), .drop(p2c_drop[k])
    );
  end

  vp_mbox_side #(.CHANNELS(CHANNELS), .BASE(C_BASE), .VEC(C_VEC)) u_c (
    .clk(PIN_CLK), .rst_n(PIN_nINIT), .ad_in(PIN_nADC_in), .ad_out(PIN_nADC_out),
    .ad_oe(PIN_nADC_oe), .sync_n(PIN_nSYNCC), .din_n(PIN_nDINC), .dout_n(PIN_nDOUTC),
    .iaki_n(PIN_nIAKIC), .rply_n(PIN_nRPLYC), .virq_n(PIN_nVIRQC), .iako_n(PIN_nIAKOC),
    .push(c_push), .push_data(c_push_data), .pop(c_pop), .rx_empty(p2c_empty),
    .rx_head(p2c_head), .tx_full(c2p_full), .tx_drop(c2p_drop)
  );

  vp_mbox_side #(.CHANNELS(CHANNELS), .BASE(P_BASE), .VEC(P_VEC)) u_p (
    .clk(PIN_CLK), .rst_n(PIN_nINIT), .ad_in(PIN_nADP_in), .ad_out(PIN_nADP_out),
    .ad_oe(PIN_nADP_oe), .sync_n(PIN_nSYNCP), .din_n(PIN_nDINP), .dout_n(PIN_nDOUTP),
    .iaki_n(PIN_nIAKIP), .rply_n(PIN_nRPLYP), .virq_n(PIN_nVIRQP), .iako_n(PIN_nIAKOP),
    .push(p_push), .push_data(p_push_data), .pop(p_pop), .rx_empty(c2p_empty),
    .rx_head(c2p_head), .tx_full(p2c_full), .tx_drop(p2c_drop)
  );
endmodule

// File: tb/tb_vp_mbox.sv
// tb_vp_mbox: directed and random Qbus traffic on both sides of vp_mbox, compared against
// a queue-based model of the channel FIFOs, control bits and interrupt vectors.
`timescale 1ns/1ps
module tb_vp_mbox;
  localparam int          CHANNELS = 3;
  localparam int          DEPTH    = 4;
  localparam logic [15:0] C_BASE   = 16'o176640;
  localparam logic [15:0] P_BASE   = 16'o177040;
  localparam logic [15:0] C_VEC    = 16'o000440;
  localparam logic [15:0] P_VEC    = 16'o000300;

  logic             clk = 1'b0;
  logic             n_init;
  logic [1:0][15:0] nad_in, nad_out;
  logic [1:0]       oe, nsync, ndin, ndout, niaki, nrply, nvirq, niako;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: q[0][ch] is C->P, q[1][ch] is P->C; side s transmits into q[s] and receives from q[1-s].
  logic [7:0]                q [2][CHANNELS][$];
  logic [1:0][CHANNELS-1:0]  rie, xie, xovr;

  logic [15:0] rd, exp_v;
  bit          rep, rep2, iako_low;
  int          lat, lat2;

  always #5 clk = ~clk;

  vp_mbox #(
    .CHANNELS(CHANNELS), .DEPTH(DEPTH), .C_BASE(C_BASE), .P_BASE(P_BASE),
    .C_VEC(C_VEC), .P_VEC(P_VEC)
  ) dut (
    .PIN_CLK(clk), .PIN_nINIT(n_init),
    .PIN_nADC_in(nad_in[0]), .PIN_nADC_out(nad_out[0]), .PIN_nADC_oe(oe[0]),
    .PIN_nSYNCC(nsync[0]), .PIN_nDINC(ndin[0]), .PIN_nDOUTC(ndout[0]), .PIN_nIAKIC(niaki[0]),
    .PIN_nRPLYC(nrply[0]), .PIN_nVIRQC(nvirq[0]), .PIN_nIAKOC(niako[0]),
    .PIN_nADP_in(nad_in[1]), .PIN_nADP_out(nad_out[1]), .PIN_nADP_oe(oe[1]),
    .PIN_nSYNCP(nsync[1]), .PIN_nDINP(ndin[1]), .PIN_nDOUTP(ndout[1]), .PIN_nIAKIP(niaki[1]),
    .PIN_nRPLYP(nrply[1]), .PIN_nVIRQP(nvirq[1]), .PIN_nIAKOP(niako[1])
  );

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %06o expected %06o", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] addr_of(input int s, input int ch, input int r);
    return (s == 0 ? C_BASE : P_BASE) + 16'(8 * ch + 2 * r);
  endfunction

  task automatic model_read(input int s, input int ch, input int r, output logic [15:0] v);
    v = '0;
    case (r)
      0: v = {8'd0, q[1-s][ch].size() != 0, rie[s][ch], 6'd0};
      1: if (q[1-s][ch].size() != 0) v = {8'd0, q[1-s][ch].pop_front()};
      2: v = {xovr[s][ch], 7'd0, q[s][ch].size() < DEPTH, xie[s][ch], 6'd0};
      default: v = '0;
    endcase
  endtask

  task automatic model_write(input int s, input int ch, input int r, input logic [15:0] d);
    case (r)
      0: rie[s][ch] = d[6];
      2: begin xie[s][ch] = d[6]; xovr[s][ch] = 1'b0; end
      3: if (q[s][ch].size() < DEPTH) q[s][ch].push_back(d[7:0]); else xovr[s][ch] = 1'b1;
      default: ;
    endcase
  endtask

  function automatic logic model_virq_n(input int s);
    for (int ch = 0; ch < CHANNELS; ch++) begin
      if (rie[s][ch] && q[1-s][ch].size() != 0) return 1'b0;
      if (xie[s][ch] && q[s][ch].size() < DEPTH) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [15:0] model_vector(input int s);
    logic [15:0] base = (s == 0) ? C_VEC : P_VEC;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      if (rie[s][ch] && q[1-s][ch].size() != 0) return base + 16'(8 * ch);
      if (xie[s][ch] && q[s][ch].size() < DEPTH) return base + 16'(8 * ch + 4);
    end
    return 16'd0;
  endfunction

  task automatic bus_read(input int s, input logic [15:0] addr, output logic [15:0] data,
                          output bit replied, output int cycles);
    data = '0; replied = 1'b0; cycles = 0;
    @(negedge clk);
    nad_in[s] = ~addr; nsync[s] = 1'b0;
    @(negedge clk);
    nad_in[s] = 16'hFFFF; ndin[s] = 1'b0;
    for (int i = 0; i < 12 && !replied; i++) begin
      @(negedge clk);
      cycles++;
      if (!nrply[s]) begin
        replied = 1'b1;
        data = oe[s] ? ~nad_out[s] : 16'hDEAD;
      end
    end
    ndin[s] = 1'b1;
    for (int i = 0; i < 12 && !nrply[s]; i++) @(negedge clk);
    nsync[s] = 1'b1;
  endtask

  task automatic bus_write(input int s, input logic [15:0] addr, input logic [15:0] data,
                           output bit replied, output int cycles);
    replied = 1'b0; cycles = 0;
    @(negedge clk);
    nad_in[s] = ~addr; nsync[s] = 1'b0;
    @(negedge clk);
    nad_in[s] = ~data; ndout[s] = 1'b0;
    for (int i = 0; i < 12 && !replied; i++) begin
      @(negedge clk);
      cycles++;
      if (!nrply[s]) replied = 1'b1;
    end
    ndout[s] = 1'b1;
    for (int i = 0; i < 12 && !nrply[s]; i++) @(negedge clk);
    nsync[s] = 1'b1; nad_in[s] = 16'hFFFF;
  endtask

  task automatic bus_iak(input int s, output logic [15:0] vec, output bit replied,
                         output bit saw_iako_low);
    vec = '0; replied = 1'b0; saw_iako_low = 1'b0;
    @(negedge clk);
    nad_in[s] = 16'hFFFF; nsync[s] = 1'b0; ndin[s] = 1'b0;
    @(negedge clk);
    niaki[s] = 1'b0;
    for (int i = 0; i < 12 && !replied; i++) begin
      @(negedge clk);
      if (!niako[s]) saw_iako_low = 1'b1;
      if (!nrply[s]) begin
        replied = 1'b1;
        vec = oe[s] ? ~nad_out[s] : 16'hDEAD;
      end
    end
    ndin[s] = 1'b1;
    for (int i = 0; i < 12 && !nrply[s]; i++) @(negedge clk);
    niaki[s] = 1'b1; nsync[s] = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic apply_read(input int s, input int ch, input int r, input string tag);
    logic [15:0] d, e;
    bit ok;
    int c;
    bus_read(s, addr_of(s, ch, r), d, ok, c);
    model_read(s, ch, r, e);
    check_output({tag, " reply"}, {15'd0, ok}, 16'd1);
    check_output(tag, d, e);
  endtask

  task automatic apply_write(input int s, input int ch, input int r, input logic [15:0] d,
                             input string tag);
    bit ok;
    int c;
    bus_write(s, addr_of(s, ch, r), d, ok, c);
    model_write(s, ch, r, d);
    check_output({tag, " reply"}, {15'd0, ok}, 16'd1);
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++)
      for (int ch = 0; ch < CHANNELS; ch++) q[s][ch].delete();
    rie = '0; xie = '0; xovr = '0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s, ch, r, op;
    logic [15:0] d;

    n_init = 1'b0; nad_in = '1; nsync = '1; ndin = '1; ndout = '1; niaki = '1;
    model_reset();
    repeat (4) @(negedge clk);
    check_output("reset nRPLY", {14'd0, nrply}, 16'd3);
    check_output("reset nVIRQ", {14'd0, nvirq}, 16'd3);
    check_output("reset nIAKO", {14'd0, niako}, 16'd3);
    check_output("reset oe", {14'd0, oe}, 16'd0);
    check_output("reset nADC_out", nad_out[0], 16'hFFFF);
    check_output("reset nADP_out", nad_out[1], 16'hFFFF);
    n_init = 1'b1;
    @(negedge clk);

    $display("[TB] register reset values");
    for (int si = 0; si < 2; si++)
      for (int ci = 0; ci < CHANNELS; ci++)
        for (int ri = 0; ri < 4; ri++)
          apply_read(si, ci, ri, $sformatf("init s%0d ch%0d r%0d", si, ci, ri));
    bus_read(0, addr_of(0, 0, 2), rd, rep, lat);
    check_output("init C XCSR literal", rd, 16'o000200);

    $display("[TB] single byte C to P on channel 1");
    bus_write(0, 16'o176656, 16'o000101, rep, lat);
    model_write(0, 1, 3, 16'o000101);
    check_output("wr latency", 16'(lat), 16'd2);
    bus_read(1, addr_of(1, 1, 0), rd, rep, lat);
    check_output("rd latency", 16'(lat), 16'd3);
    check_output("P RCSR1 full", rd, 16'o000200);
    bus_read(1, addr_of(1, 1, 1), rd, rep, lat);
    model_read(1, 1, 1, exp_v);
    check_output("P RBUF1", rd, 16'o000101);
    apply_read(1, 1, 0, "P RCSR1 empty");

    $display("[TB] overflow on channel 0");
    for (int b = 1; b <= DEPTH + 1; b++) apply_write(0, 0, 3, 16'(b), $sformatf("C XBUF0 b%0d", b));
    bus_read(0, addr_of(0, 0, 2), rd, rep, lat);
    model_read(0, 0, 2, exp_v);
    check_output("C XCSR0 ovr", rd, 16'o100000);
    check_output("C XCSR0 model", rd, exp_v);
    for (int b = 1; b <= DEPTH; b++) begin
      bus_read(1, addr_of(1, 0, 1), rd, rep, lat);
      model_read(1, 0, 1, exp_v);
      check_output($sformatf("P RBUF0 order %0d", b), rd, 16'(b));
    end
    apply_write(0, 0, 2, 16'o000000, "C XCSR0 clr");
    apply_read(0, 0, 2, "C XCSR0 after clr");

    $display("[TB] address decode holes");
    bus_read(0, C_BASE + 16'd1, rd, rep, lat);
    check_output("odd addr no reply", {15'd0, rep}, 16'd0);
    bus_read(1, P_BASE + 16'(8 * CHANNELS), rd, rep, lat);
    check_output("beyond window no reply", {15'd0, rep}, 16'd0);

    $display("[TB] P interrupt priority");
    apply_write(1, 2, 0, 16'o000100, "P RCSR2 rie");
    apply_write(1, 0, 2, 16'o000100, "P XCSR0 xie");
    apply_write(0, 2, 3, 16'o000052, "C XBUF2");
    check_output("P virq asserted", {15'd0, nvirq[1]}, {15'd0, model_virq_n(1)});
    bus_iak(1, rd, rep, iako_low);
    check_output("P iak reply", {15'd0, rep}, 16'd1);
    check_output("P iak vec ch0 tx", rd, model_vector(1));
    check_output("P iak vec literal", rd, P_VEC + 16'd4);
    check_output("P iako held high", {15'd0, iako_low}, 16'd0);
    apply_write(1, 0, 2, 16'o000000, "P XCSR0 clr");
    bus_iak(1, rd, rep, iako_low);
    check_output("P iak vec ch2 rx", rd, P_VEC + 16'o20);
    check_output("P iak vec model", rd, model_vector(1));
    apply_read(1, 2, 1, "P RBUF2");
    check_output("P virq released", {15'd0, nvirq[1]}, 16'd1);
    apply_write(1, 2, 0, 16'o000000, "P RCSR2 clr");

    $display("[TB] C acknowledge with no request");
    bus_iak(0, rd, rep, iako_low);
    check_output("C iak no reply", {15'd0, rep}, 16'd0);
    check_output("C iako passes", {15'd0, iako_low}, 16'd1);

    $display("[TB] push to full FIFO with simultaneous pop");
    for (int b = 0; b < DEPTH; b++) apply_write(0, 0, 3, 16'h11 + 16'(b), "C XBUF0 fill");
    fork
      bus_read(1, addr_of(1, 0, 1), rd, rep, lat);
      begin
        @(negedge clk);
        bus_write(0, addr_of(0, 0, 3), 16'h0055, rep2, lat2);
      end
    join
    model_read(1, 0, 1, exp_v);
    model_write(0, 0, 3, 16'h0055);
    check_output("concurrent pop data", rd, exp_v);
    check_output("concurrent push reply", {15'd0, rep2}, 16'd1);
    apply_read(0, 0, 2, "C XCSR0 no ovr");
    for (int b = 0; b < DEPTH; b++) apply_read(1, 0, 1, $sformatf("P RBUF0 drain %0d", b));

    $display("[TB] random traffic");
    for (int n = 0; n < 250; n++) begin
      s  = $urandom_range(0, 1);
      ch = $urandom_range(0, CHANNELS - 1);
      op = $urandom_range(0, 9);
      d  = 16'($urandom);
      if (op <= 3)      apply_write(s, ch, 3, d, $sformatf("rnd%0d XBUF", n));
      else if (op <= 6) apply_read(s, ch, 1, $sformatf("rnd%0d RBUF", n));
      else if (op == 7) begin
        r = $urandom_range(0, 1) * 2;
        apply_read(s, ch, r, $sformatf("rnd%0d CSR%0d", n, r));
      end else if (op == 8) apply_write(s, ch, 2, d, $sformatf("rnd%0d XCSR", n));
      else              apply_write(s, ch, 0, d, $sformatf("rnd%0d RCSR", n));
      check_output($sformatf("rnd%0d virqC", n), {15'd0, nvirq[0]}, {15'd0, model_virq_n(0)});
      check_output($sformatf("rnd%0d virqP", n), {15'd0, nvirq[1]}, {15'd0, model_virq_n(1)});
      if (op == 9 && !nvirq[s]) begin
        bus_iak(s, rd, rep, iako_low);
        check_output($sformatf("rnd%0d vector", n), rd, model_vector(s));
      end
    end

    $display("[TB] reset during a read");
    apply_write(0, 0, 3, 16'h00A5, "C XBUF0 pre-reset");
    @(negedge clk);
    nad_in[1] = ~addr_of(1, 0, 1); nsync[1] = 1'b0;
    @(negedge clk);
    nad_in[1] = 16'hFFFF; ndin[1] = 1'b0;
    rep = 1'b0;
    for (int i = 0; i < 12 && !rep; i++) begin
      @(negedge clk);
      if (!nrply[1]) rep = 1'b1;
    end
    check_output("mid-read reply seen", {15'd0, rep}, 16'd1);
    n_init = 1'b0;
    @(negedge clk);
    check_output("reset nRPLYP", {15'd0, nrply[1]}, 16'd1);
    check_output("reset oeP", {15'd0, oe[1]}, 16'd0);
    n_init = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_output("post reset no reply", {15'd0, nrply[1]}, 16'd1);
    ndin[1] = 1'b1; nsync[1] = 1'b1;
    @(negedge clk);
    for (int si = 0; si < 2; si++)
      for (int ci = 0; ci < CHANNELS; ci++)
        for (int ri = 0; ri < 3; ri++)
          apply_read(si, ci, ri, $sformatf("post s%0d ch%0d r%0d", si, ci, ri));
    check_output("post reset nVIRQ", {14'd0, nvirq}, 16'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
